// File: rtl/mips_pkg.sv
// Shared register-file types for the writeback path.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    // One pending register write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_fwd_match.sv
// Address match over an age-ordered list of pending writes; youngest hit wins.
// Slot 0 is the oldest entry, slot N-1 the youngest.
module reg_fwd_match
    import mips_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  wb_entry_t [N-1:0]       entries,
    input  logic [N-1:0]            valid,
    input  logic [REG_ADDR_W-1:0]   raddr,
    output logic                    hit,
    output logic [REG_DATA_W-1:0]   data
);

    // Scan oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid[i] && (raddr != '0) && (entries[i].addr == raddr)) begin
                hit  = 1'b1;
                data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register writeback queue: buffers register-file writes in order, drains one
// per cycle when the register file is not stalled, and optionally forwards
// pending values to the read ports.
// Optional feature macro: REG_WRITEBACK_BYPASS_EN (bypass logic compiled in).
module reg_writeback
    import mips_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [REG_ADDR_W-1:0]   wb_addr,
    input  logic [REG_DATA_W-1:0]   wb_data,
    input  logic                    rf_stall,
    output logic                    writeFlag,
    output logic [REG_ADDR_W-1:0]   regWrt,
    output logic [REG_DATA_W-1:0]   inData,
    input  logic [REG_ADDR_W-1:0]   read1,
    input  logic [REG_ADDR_W-1:0]   read2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [REG_DATA_W-1:0]   fwd_data1,
    output logic [REG_DATA_W-1:0]   fwd_data2,
    output logic [CNT_W-1:0]        pending
);

    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               enq;
    logic               deq;

    // Full queue refuses offers even if it drains this cycle; r0 writes are accepted and dropped.
    assign wb_ready = (count < FULL);
    assign enq      = wb_valid && wb_ready && (wb_addr != '0);
    assign deq      = (count != '0) && !rf_stall;
    assign pending  = count;

    // Entry storage; contents need no reset since occupancy gates every use.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{addr: wb_addr, data: wb_data};
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            writeFlag <= 1'b0;
            regWrt    <= '0;
            inData    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            writeFlag <= deq;
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                regWrt <= mem[rd_ptr].addr;
                inData <= mem[rd_ptr].data;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef REG_WRITEBACK_BYPASS_EN
    localparam int unsigned NSLOT = DEPTH + 1;

    wb_entry_t [NSLOT-1:0] age_entries;
    logic [NSLOT-1:0]      age_valid;

    // Age-ordered view: the write on the port is oldest, then queue head to tail.
    always_comb begin
        age_entries[0] = '{addr: regWrt, data: inData};
        age_valid[0]   = writeFlag;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_entries[i+1] = mem[rd_ptr + PTR_W'(i)];
            age_valid[i+1]   = (CNT_W'(i) < count);
        end
    end

    reg_fwd_match #(.N(NSLOT)) u_fwd1 (
        .entries (age_entries),
        .valid   (age_valid),
        .raddr   (read1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    reg_fwd_match #(.N(NSLOT)) u_fwd2 (
        .entries (age_entries),
        .valid   (age_valid),
        .raddr   (read2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );
`else
    logic unused_read;

    assign fwd_hit1    = 1'b0;
    assign fwd_hit2    = 1'b0;
    assign fwd_data1   = '0;
    assign fwd_data2   = '0;
    assign unused_read = ^{read1, read2};
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_reg_writeback;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef REG_WRITEBACK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        rf_stall;
    logic        writeFlag;
    logic [4:0]  regWrt;
    logic [31:0] inData;
    logic [4:0]  read1, read2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [2:0]  pending;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    wb_entry_t   q[$];
    bit          m_wf;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_stall(rf_stall),
        .writeFlag(writeFlag), .regWrt(regWrt), .inData(inData),
        .read1(read1), .read2(read2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    // Youngest pending write to a register, looking at the port and the queue.
    function automatic void model_fwd(input logic [4:0] ra, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (BYP && ra != 5'd0) begin
            if (m_wf && m_addr == ra) begin
                hit = 1'b1;
                d   = m_data;
            end
            foreach (q[i]) begin
                if (q[i].addr == ra) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
        end
    endfunction

    // Model update: one register write drains per unstalled cycle, accepted non-r0 writes queue.
    always @(posedge clk) begin
        bit ready;
        if (!rst_n) begin
            q.delete();
            m_wf   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            ready = (q.size() < DEPTH);
            if (q.size() > 0 && !rf_stall) begin
                m_wf   = 1'b1;
                m_addr = q[0].addr;
                m_data = q[0].data;
                void'(q.pop_front());
            end else begin
                m_wf = 1'b0;
            end
            if (wb_valid && ready && wb_addr != 5'd0)
                q.push_back('{addr: wb_addr, data: wb_data});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit h1, h2;
        logic [31:0] d1, d2;
        if (chk_en) begin
            model_fwd(read1, h1, d1);
            model_fwd(read2, h2, d2);
            chk("m_wb_ready",  32'(wb_ready),  32'(q.size() < DEPTH));
            chk("m_pending",   32'(pending),   q.size());
            chk("m_writeFlag", 32'(writeFlag), 32'(m_wf));
            chk("m_regWrt",    32'(regWrt),    32'(m_addr));
            chk("m_inData",    inData,         m_data);
            chk("m_fwd_hit1",  32'(fwd_hit1),  32'(h1));
            chk("m_fwd_data1", fwd_data1,      d1);
            chk("m_fwd_hit2",  32'(fwd_hit2),  32'(h2));
            chk("m_fwd_data2", fwd_data2,      d2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rf_stall = 1'b0;
        read1    = '0;
        read2    = '0;
        tick();
        chk_en = 1'b1;
        tick();
        // Reset state
        chk("rst_wb_ready",  32'(wb_ready),  32'd1);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_writeFlag", 32'(writeFlag), 32'd0);
        chk("rst_regWrt",    32'(regWrt),    32'd0);
        chk("rst_inData",    inData,         32'd0);
        chk("rst_fwd_hit1",  32'(fwd_hit1),  32'd0);
        chk("rst_fwd_hit2",  32'(fwd_hit2),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single write r3 = 0x11: writeFlag two cycles after acceptance
        put(5'd3, 32'h11);
        chk("lat_n1_writeFlag", 32'(writeFlag), 32'd0);
        chk("lat_n1_pending",   32'(pending),   32'd1);
        tick();
        chk("lat_n2_writeFlag", 32'(writeFlag), 32'd1);
        chk("lat_n2_regWrt",    32'(regWrt),    32'd3);
        chk("lat_n2_inData",    inData,         32'h11);
        tick();
        chk("lat_n3_writeFlag", 32'(writeFlag), 32'd0);
        chk("lat_n3_regWrt",    32'(regWrt),    32'd3);

        // Fill under stall, offer while full, then drain in order
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) put(5'(i), 32'h100 + 32'(i));
        chk("full_wb_ready", 32'(wb_ready), 32'd0);
        chk("full_pending",  32'(pending),  32'd4);
        put(5'd9, 32'hDEAD);
        chk("full_blocked_pending", 32'(pending), 32'd4);
        repeat (3) tick();
        chk("stall_hold_writeFlag", 32'(writeFlag), 32'd0);
        chk("stall_hold_pending",   32'(pending),   32'd4);
        rf_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_writeFlag", 32'(writeFlag), 32'd1);
            chk("drain_regWrt",    32'(regWrt),    32'(i));
            chk("drain_inData",    inData,         32'h100 + 32'(i));
        end
        tick();
        chk("drain_done_writeFlag", 32'(writeFlag), 32'd0);
        chk("drain_done_pending",   32'(pending),   32'd0);

        // r0 write is accepted and discarded
        chk("r0_ready", 32'(wb_ready), 32'd1);
        put(5'd0, 32'hFFFF_FFFF);
        chk("r0_pending", 32'(pending), 32'd0);
        tick();
        chk("r0_writeFlag", 32'(writeFlag), 32'd0);

        // Forwarding: youngest of two writes to r5
        rf_stall = 1'b1;
        put(5'd5, 32'hA);
        read1 = 5'd5;
        read2 = 5'd6;
        #1;
        chk("fwd_one_hit1",  32'(fwd_hit1), 32'(BYP));
        chk("fwd_one_data1", fwd_data1,     BYP ? 32'hA : 32'h0);
        put(5'd5, 32'hB);
        #1;
        chk("fwd_hit1",  32'(fwd_hit1), 32'(BYP));
        chk("fwd_data1", fwd_data1,     BYP ? 32'hB : 32'h0);
        chk("fwd_hit2",  32'(fwd_hit2), 32'd0);
        chk("fwd_data2", fwd_data2,     32'd0);
        rf_stall = 1'b0;
        tick();
        chk("fwd_port_a_data1", fwd_data1, BYP ? 32'hB : 32'h0);
        tick();
        chk("fwd_port_b_hit1",  32'(fwd_hit1), 32'(BYP));
        chk("fwd_port_b_data1", fwd_data1,     BYP ? 32'hB : 32'h0);
        tick();
        chk("fwd_idle_hit1", 32'(fwd_hit1), 32'd0);
        read1 = 5'd0;
        read2 = 5'd0;

        // Steady state at occupancy 2: accept and drain together, pointers wrap
        rf_stall = 1'b1;
        put(5'd10, 32'h1000);
        put(5'd11, 32'h1001);
        chk("ss_pending_init", 32'(pending), 32'd2);
        rf_stall = 1'b0;
        wb_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            wb_addr = 5'(11 + k);
            wb_data = 32'h1001 + 32'(k);
            tick();
            chk("ss_pending",   32'(pending),   32'd2);
            chk("ss_writeFlag", 32'(writeFlag), 32'd1);
            chk("ss_regWrt",    32'(regWrt),    32'(9 + k));
            chk("ss_inData",    inData,         32'h0FFF + 32'(k));
        end
        wb_valid = 1'b0;
        repeat (3) tick();
        chk("ss_empty", 32'(pending), 32'd0);

        // Reset with entries pending drops them
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) put(5'(20 + i), 32'h2000 + 32'(i));
        chk("mid_pending", 32'(pending), 32'd3);
        rf_stall = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_writeFlag", 32'(writeFlag), 32'd0);
        chk("mid_rst_pending",   32'(pending),   32'd0);
        chk("mid_rst_wb_ready",  32'(wb_ready),  32'd1);
        tick();
        chk("post_rst_writeFlag", 32'(writeFlag), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-queue entries; power of two, 2..16.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port wb_valid  in  1  producer offers a register write this cycle.
REQ-005 SHALL have port wb_ready  out  1  queue accepts offer; transfer when wb_valid && wb_ready.
REQ-006 SHALL have ports wb_addr  in  5  destination register, and wb_data  in  32  write value.
REQ-007 SHALL have port rf_stall  in  1  register file cannot accept a write this cycle.
REQ-008 SHALL have ports writeFlag  out  1, regWrt  out  5, inData  out  32  register-file write port.
REQ-009 SHALL have ports read1, read2  in  5 each  register addresses currently being read.
REQ-010 SHALL have ports fwd_hit1, fwd_hit2  out  1 each, and fwd_data1, fwd_data2  out  32 each  bypass results.
REQ-011 SHALL have port pending  out  log2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL hold writes in an in-order FIFO of DEPTH {addr, data} entries.
REQ-013 SHALL drive wb_ready = 1 iff occupancy < DEPTH; no same-cycle dequeue credit when full.
REQ-014 SHALL silently accept and discard transfers with wb_addr == 0: no enqueue, no write.
REQ-015 SHALL register writeFlag/regWrt/inData: when occupancy > 0 and rf_stall = 0, next cycle presents head entry with writeFlag = 1 and pops it; otherwise writeFlag = 0 next cycle, regWrt/inData hold.
REQ-016 SHALL give 2-cycle min latency from accepted transfer to writeFlag (cycle N accept, cycle N+1 head, N+2 writeFlag).
REQ-017 SHALL support simultaneous enqueue and dequeue in one cycle; occupancy unchanged.
REQ-018 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-019 SHALL compute bypass combinationally: fwd_hitN = 1 iff readN != 0 and readN matches a queued entry or the entry currently on regWrt with writeFlag = 1; fwd_dataN = youngest matching entry's data, else 0.
REQ-020 SHALL treat an entry as queued from the cycle after acceptance; same-cycle wb_* inputs are not forwarded.
REQ-021 SHALL keep rf_stall asserted indefinitely legal; no entry lost or reordered.

Reset
REQ-022 SHALL, with rst_n = 0 at a rising edge, clear occupancy and pointers, writeFlag = 0, regWrt = 0, inData = 0.
REQ-023 SHALL drop all queued entries on reset mid-operation; no write issued in cycle after reset.
REQ-024 SHALL drive wb_ready = 1, pending = 0, fwd_hit1/2 = 0 after reset.

Configuration
REQ-025 SHALL compile bypass logic only when REG_WRITEBACK_BYPASS_EN is defined.
REQ-026 SHALL, without REG_WRITEBACK_BYPASS_EN, tie fwd_hit1/2 = 0 and fwd_data1/2 = 0; ports remain present.

Structure
REQ-027 SHALL take REG_ADDR_W = 5, REG_DATA_W = 32 and a wb_entry_t {addr, data} typedef from shared package mips_pkg.
REQ-028 SHALL place the address-match/youngest-select in sub-module reg_fwd_match, instantiated twice.

Verification
REQ-029 SHALL check: reset, then write r3 = 0x11 -> writeFlag = 1, regWrt = 3, inData = 0x11 two cycles after acceptance.
REQ-030 SHALL check: 4 writes with rf_stall = 1 -> wb_ready = 0, pending = 4; release rf_stall -> 4 writes in 4 consecutive cycles in order.
REQ-031 SHALL check: write r0 = 0xFFFF_FFFF -> accepted, pending stays 0, no writeFlag.
REQ-032 SHALL check: queue r5 = 0xA then r5 = 0xB under stall, read1 = 5 -> fwd_hit1 = 1, fwd_data1 = 0xB; read2 = 6 -> fwd_hit2 = 0.
REQ-033 SHALL check: occupancy 2, simultaneous accept and drain for 10 cycles -> pending stays 2, pointers wrap, order preserved.
REQ-034 SHALL check: rst_n low with 3 entries pending -> next cycle writeFlag = 0, pending = 0, wb_ready = 1.
